// File: rtl/mdu_defs.sv
// rtl/mdu_defs.sv - shared op/state encodings and counter sizing for the multiply/divide unit
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MADD  = 3'd6,
    MDU_MADDU = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Counter must hold max(latency)-1; keep at least one bit so a 1-cycle build still elaborates.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int mx;
    mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// rtl/mdu_div.sv - combinational signed/unsigned divider with truncating quotient and zero-divisor flag
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend.
  // MIN/-1 needs no special path: |MIN| is MIN as an unsigned value, so the quotient negates back to MIN with remainder 0.
  always_comb begin
    neg_a    = is_signed & a[WIDTH-1];
    neg_b    = is_signed & b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = (b == '0);
    uq       = '0;
    ur       = '0;
    if (!div_zero) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? -uq : uq;
    rem = neg_a ? -ur : ur;
  end

endmodule

// File: rtl/mdu_pipe.sv
// rtl/mdu_pipe.sv - multi-cycle multiply/divide unit with HI/LO and busy; MDU_MADD_EN enables MADD/MADDU
module mdu_pipe
  import mdu_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW        = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  mdu_state_e         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   stage_hi;
  logic [WIDTH-1:0]   stage_lo;
  logic               stage_zero;
`ifdef MDU_MADD_EN
  logic               stage_acc;
`endif

  logic               is_mul;
  logic               is_div;
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               div_zero;

  // Decode the request and form the 2*WIDTH product; extending before multiplying gives signed and unsigned results alike.
  always_comb begin
    is_div     = (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
    is_mul     = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) || (op == MDU_MADDU);
    mul_signed = (op == MDU_MULT) || (op == MDU_MADD);
`else
    is_mul     = (op == MDU_MULT) || (op == MDU_MULTU);
    mul_signed = (op == MDU_MULT);
`endif
    ext_a      = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
    ext_b      = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
    product    = ext_a * ext_b;
  end

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .a         (a),
    .b         (b),
    .is_signed (op == MDU_DIV),
    .quo       (div_quo),
    .rem       (div_rem),
    .div_zero  (div_zero)
  );

  // FSM: results are staged at accept, counted down, and only then copied into HI/LO so reads see old values while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      stage_hi   <= '0;
      stage_lo   <= '0;
      stage_zero <= 1'b0;
`ifdef MDU_MADD_EN
      stage_acc  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              {stage_hi, stage_lo} <= product;
              stage_zero <= 1'b0;
              count      <= MULT_LOAD;
              state      <= ST_RUN;
              busy       <= 1'b1;
            end else if (is_div) begin
              stage_hi   <= div_rem;
              stage_lo   <= div_quo;
              stage_zero <= div_zero;
              count      <= DIV_LOAD;
              state      <= ST_RUN;
              busy       <= 1'b1;
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
`ifdef MDU_MADD_EN
            stage_acc <= (op == MDU_MADD) || (op == MDU_MADDU);
`endif
          end
        end
        ST_RUN: begin
          if (count == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
`ifdef MDU_MADD_EN
            if (stage_acc) begin
              {hi, lo} <= {hi, lo} + {stage_hi, stage_lo};
            end else
`endif
            if (!stage_zero) begin
              hi <= stage_hi;
              lo <= stage_lo;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_pipe.sv
// tb/tb_mdu_pipe.sv - self-checking bench for mdu_pipe against an arithmetic reference model
module tb_mdu_pipe;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [31:0] mhi;
  logic [31:0] mlo;

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics computed with plain wide integer arithmetic; returns expected busy length.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    longint      sp;
    logic [63:0] up;
    int          sx;
    int          sy;
    sx  = x;
    sy  = y;
    lat = 0;
    sp  = longint'(sx) * longint'(sy);
    up  = {32'h0, x} * {32'h0, y};
    case (o)
      3'd0: begin {mhi, mlo} = sp; lat = MC; end
      3'd1: begin {mhi, mlo} = up; lat = MC; end
      3'd2: begin
        lat = DC;
        if (sy != 0) begin
          if (sx == 32'sh8000_0000 && sy == -1) begin
            mlo = x;
            mhi = 0;
          end else begin
            mlo = sx / sy;
            mhi = sx % sy;
          end
        end
      end
      3'd3: begin
        lat = DC;
        if (y != 0) begin
          mlo = x / y;
          mhi = x % y;
        end
      end
      3'd4: mhi = x;
      3'd5: mlo = x;
`ifdef MDU_MADD_EN
      3'd6: begin {mhi, mlo} = {mhi, mlo} + sp; lat = MC; end
      3'd7: begin {mhi, mlo} = {mhi, mlo} + up; lat = MC; end
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input int pre, input int lat,
                           input logic [31:0] ohi, input logic [31:0] olo);
    int n;
    n = pre;
    while (busy === 1'b1 && n < lat + 20) begin
      chk({tag, "_hold"}, {hi, lo}, {ohi, olo});
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_busy_len"}, 64'(n), 64'(lat));
    chk({tag, "_hilo"}, {hi, lo}, {mhi, mlo});
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    logic [31:0] ohi;
    logic [31:0] olo;
    ohi = mhi;
    olo = mlo;
    issue(o, x, y);
    model_op(o, x, y, lat);
    if (lat == 0) begin
      chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
      chk({tag, "_hilo"}, {hi, lo}, {mhi, mlo});
    end else begin
      wait_done(tag, 0, lat, ohi, olo);
    end
  endtask

  initial begin
    int          lat;
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    checks = 0;
    errors = 0;
    mhi    = 0;
    mlo    = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    a      = 32'h0;
    b      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {31'h0, busy, hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("divu", 3'd3, 32'd100, 32'd7);
    chk("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op("mthi", 3'd4, 32'h11, 32'h0);
    run_op("mtlo", 3'd5, 32'h22, 32'h0);
    run_op("div_zero", 3'd2, 32'd5, 32'd0);
    chk("div_zero_const", {hi, lo}, {32'h11, 32'h22});
    run_op("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start issued while busy must be ignored entirely.
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd5;
    a     = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_op(3'd1, 32'hFFFF_FFFF, 32'd2, lat);
    wait_done("multu_ignore", 1, lat, 32'h0, 32'h8000_0000);
    chk("multu_ignore_const", {hi, lo}, {32'h1, 32'hFFFF_FFFE});

    run_op("pre_hi", 3'd4, 32'h0, 32'h0);
    run_op("pre_lo", 3'd5, 32'hFFFF_FFFF, 32'h0);
    run_op("op7", 3'd7, 32'd1, 32'd1);
    run_op("op6", 3'd6, 32'hFFFF_FFFE, 32'd3);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      if (i % 6 == 1) ry = 0;
      if (i % 6 == 3) ry = 32'($urandom_range(1, 9));
      if (i == 8) begin ro = 3'd2; rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry);
    end

    // Reset in the middle of a divide discards the pending result.
    run_op("pre_rst", 3'd4, 32'h55, 32'h0);
    issue(3'd3, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset", {31'h0, busy, hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1;
    chk("after_reset", {31'h0, busy, hi, lo}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the MIPS core.
- Next generation of the single-cycle datapath: adds multi-cycle arithmetic with a busy handshake.
- Sits beside the ALU in the execute stage.
- The controller stalls dependent HI/LO reads while `busy` is high.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: multiply latency in cycles; must be ≥1.
- DIV_CYCLES, 10: divide latency in cycles; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request strobe; sampled only when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 see Optional Feature.
- a  input  WIDTH  operand rs.
- b  input  WIDTH  operand rt.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset:
  - Clock and reset: one clock `clk`; `reset` is synchronous and active-low.
  - At any edge with reset=0: state←IDLE, counter←0, busy←0, hi←0, lo←0.
  - This applies mid-operation too; a pending result is discarded.
- States: IDLE, RUN. `busy` is 1 exactly when state=RUN, and is registered.
- IDLE accepting an op:
  - Condition: start=1, busy=0, and op in 0..3.
  - At edge k, latch the result into staging registers and load counter = MULT_CYCLES-1 or DIV_CYCLES-1.
  - Enter RUN.
- RUN:
  - The counter decrements each edge.
  - At the edge where counter=0, hi/lo take the staged values and the state returns to IDLE.
  - Net effect: busy is high for exactly N cycles, and the new hi/lo are visible in the cycle after busy falls.
- MTHI/MTLO (op 4/5) with start=1, busy=0:
  - hi←a or lo←a at the same edge; busy stays 0.
- Start while busy=1: ignored completely. No queuing; staging is not disturbed.
- hi/lo hold their old values throughout RUN.
- MULT: signed 2·WIDTH product, {hi,lo}. MULTU: unsigned product.
- DIV (signed):
  - lo = quotient, truncated toward zero.
  - hi = remainder, carrying the sign of the dividend.
  - Overflow case MIN/-1: lo=MIN, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b=0, op 2/3):
  - The FSM still runs DIV_CYCLES with busy=1.
  - hi/lo are left unchanged at commit.
- Undefined op with start=1 (6/7 when the feature is off): no-op; busy stays 0.
- Operands are sampled only at the accept edge; later changes to a/b have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 6 MADD and op 7 MADDU are enabled.
  - Accept rules and MULT_CYCLES latency are the same as for MULT.
  - Commit is {hi,lo} ← {hi,lo} + signed/unsigned product, mod 2^(2·WIDTH).
  - The accumulator base is the {hi,lo} value at commit time. This equals the accept-time value, because hi/lo cannot change during RUN.
- Not defined: ops 6/7 are no-ops as above, with no accumulator logic synthesised.

Decomposition:
- Package mdu_defs holds:
  - op encodings (MDU_MULT…MDU_MADDU);
  - state encodings (ST_IDLE, ST_RUN);
  - counter width function clog2(max(MULT_CYCLES, DIV_CYCLES)).
- One sub-module, mdu_div, is natural: purely combinational signed/unsigned divide.
  - It handles truncation, remainder sign, MIN/-1 and b=0 flag generation.
  - mdu_pipe contains the FSM, counter, staging and HI/LO.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=7: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU, a=100, b=7: busy high 10 cycles, then lo=14, hi=2. DIV, a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload MTHI 0x11, MTLO 0x22 (each visible the next cycle, busy never set); then DIV a=5, b=0: busy 10 cycles, hi/lo stay 0x11/0x22.
- MULTU 0xFFFFFFFF×2 accepted; on cycle 2 of RUN issue start, MTLO a=0xDEAD: ignored; final hi=1, lo=0xFFFFFFFE.
- DIV started, reset=0 on cycle 3: busy=0 and hi=lo=0 the next cycle; no commit afterwards.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1: after 5 cycles hi=1, lo=0. Without the macro, op 6 leaves busy=0 and hi/lo unchanged.
